// File: rtl/matrix_feeder_pkg.sv
// -----------------------------------------------------------------------------
// matrix_feeder_pkg
// Shared types and constants for the systolic-array operand feeder.
//   SYS_ARRAY_SIZE : number of skewed lanes (array edge size)
//   DATA_WIDTH     : element width
//   LEN_WIDTH      : width of the vector-count field
//   matrix_data_t  : one lane element; 'last' sits above the data bits
//   vec_t          : one operand vector, element i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   FD_*           : feeder FSM state encodings
// -----------------------------------------------------------------------------
package matrix_feeder_pkg;
    localparam int SYS_ARRAY_SIZE = 2;
    localparam int DATA_WIDTH     = 8;
    localparam int LEN_WIDTH      = 16;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef struct packed {
        logic  last;
        data_t data;
    } matrix_data_t;

    typedef data_t [SYS_ARRAY_SIZE-1:0] vec_t;

    localparam logic [1:0] FD_IDLE  = 2'd0;
    localparam logic [1:0] FD_FEED  = 2'd1;
    localparam logic [1:0] FD_FLUSH = 2'd2;

    // Flush step counter only needs to reach SYS_ARRAY_SIZE-2.
    localparam int FCNT_WIDTH = (SYS_ARRAY_SIZE > 2) ? $clog2(SYS_ARRAY_SIZE - 1) : 1;
endpackage

// File: rtl/matrix_feeder_if.sv
// -----------------------------------------------------------------------------
// matrix_feeder_if
// Bundles the feeder's control, operand and lane signals.
//   slave  : the feeder itself (takes start/len/vectors, drives lanes/status)
//   master : the operand source / controller
// Optional macro MATRIX_FEEDER_STALL_CNT_EN adds stall_cnt_o (32 bits).
// -----------------------------------------------------------------------------
interface matrix_feeder_if;
    import matrix_feeder_pkg::*;

    logic                                    start_i;
    logic [LEN_WIDTH-1:0]                    len_i;
    logic                                    vec_valid_i;
    logic                                    vec_ready_o;
    vec_t                                    vec_data_i;
    logic [SYS_ARRAY_SIZE*(DATA_WIDTH+1)-1:0] lane_o;
    logic                                    advance_o;
    logic                                    busy_o;
    logic                                    done_o;
`ifdef MATRIX_FEEDER_STALL_CNT_EN
    logic [31:0]                             stall_cnt_o;
`endif

    modport slave (
        input  start_i, len_i, vec_valid_i, vec_data_i,
        output vec_ready_o, lane_o, advance_o, busy_o, done_o
`ifdef MATRIX_FEEDER_STALL_CNT_EN
        , output stall_cnt_o
`endif
    );

    modport master (
        output start_i, len_i, vec_valid_i, vec_data_i,
        input  vec_ready_o, lane_o, advance_o, busy_o, done_o
`ifdef MATRIX_FEEDER_STALL_CNT_EN
        , input stall_cnt_o
`endif
    );
endinterface

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// Enable-gated shift chain of DEPTH stages, W bits wide. DEPTH=0 is a wire.
//   clk, rst : clock, async active-high reset
//   en       : shift enable (global step)
//   d / q    : chain input / output
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst, en};
            assign q = d;
        end else begin : g_chain
            logic [W-1:0] stage_reg [DEPTH];
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst)     stage_reg[gi] <= '0;
                        else if (en) stage_reg[gi] <= d;
                    end
                end else begin : g_body
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst)     stage_reg[gi] <= '0;
                        else if (en) stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
            assign q = stage_reg[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/matrix_feeder.sv
// -----------------------------------------------------------------------------
// matrix_feeder
// Transmit end of the PE operand interface: accepts operand vectors and drives
// SYS_ARRAY_SIZE skewed lanes into the systolic array edge. Lane i lags lane 0
// by i steps; 'last' marks the final element of each lane. advance_o is a
// global step enable, so input stalls freeze the array instead of injecting
// bubbles.
//   clk, rst : clock, async active-high reset
//   bus      : matrix_feeder_if.slave (start/len, vector handshake, lanes,
//              advance/busy/done status)
// Optional macro MATRIX_FEEDER_STALL_CNT_EN: adds a saturating count of FEED
// cycles without a valid vector (bus.stall_cnt_o), cleared on accepted start.
// -----------------------------------------------------------------------------
module matrix_feeder
    import matrix_feeder_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    matrix_feeder_if.slave bus
);
    localparam int N  = SYS_ARRAY_SIZE;
    localparam int MW = DATA_WIDTH + 1;

    logic [1:0]            state_reg;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic [LEN_WIDTH-1:0]  vcnt_reg;
    logic [FCNT_WIDTH-1:0] fcnt_reg;
    logic                  advance_reg;
    logic                  done_reg;

    logic beat, step, last_beat, flush_end;
    logic [N*MW-1:0] lane_bus;

    assign beat      = (state_reg == FD_FEED) && bus.vec_valid_i;
    // FLUSH steps unconditionally to push the tail of the skew out.
    assign step      = beat || (state_reg == FD_FLUSH);
    // len_reg is never 0 while in FEED, so len_reg-1 cannot wrap.
    assign last_beat = (vcnt_reg == len_reg - LEN_WIDTH'(1));
    assign flush_end = (fcnt_reg == FCNT_WIDTH'((N >= 2) ? N - 2 : 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= FD_IDLE;
            len_reg     <= '0;
            vcnt_reg    <= '0;
            fcnt_reg    <= '0;
            advance_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            advance_reg <= step;
            done_reg    <= 1'b0;
            case (state_reg)
                FD_IDLE: begin
                    if (bus.start_i) begin
                        len_reg  <= bus.len_i;
                        vcnt_reg <= '0;
                        fcnt_reg <= '0;
                        if (bus.len_i != '0) state_reg <= FD_FEED;
                        else                 done_reg  <= 1'b1;
                    end
                end
                FD_FEED: begin
                    if (beat) begin
                        vcnt_reg <= vcnt_reg + LEN_WIDTH'(1);
                        if (last_beat) begin
                            fcnt_reg <= '0;
                            if (N == 1) begin
                                // Single lane: last element is already on the edge.
                                state_reg <= FD_IDLE;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= FD_FLUSH;
                            end
                        end
                    end
                end
                FD_FLUSH: begin
                    fcnt_reg <= fcnt_reg + FCNT_WIDTH'(1);
                    if (flush_end) begin
                        state_reg <= FD_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= FD_IDLE;
            endcase
        end
    end

    // Lane i = DEPTH-i skew chain followed by the lane output register, so an
    // element accepted in cycle c shows on lane i in cycle c+1+i.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            matrix_data_t chain_in, chain_out, lane_reg;

            // Outside FEED (i.e. during FLUSH) zeros are shifted in behind the stream.
            assign chain_in = (state_reg == FD_FEED) ?
                              matrix_data_t'{last: last_beat, data: bus.vec_data_i[gi]} :
                              matrix_data_t'('0);

            skew_delay_line #(.DEPTH(gi), .W(MW)) u_skew (
                .clk (clk),
                .rst (rst),
                .en  (step),
                .d   (chain_in),
                .q   (chain_out)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst)       lane_reg <= '0;
                else if (step) lane_reg <= chain_out;
            end

            assign lane_bus[gi*MW +: MW] = lane_reg;
        end
    endgenerate

`ifdef MATRIX_FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if ((state_reg == FD_IDLE) && bus.start_i)
            stall_cnt_reg <= '0;
        else if ((state_reg == FD_FEED) && !bus.vec_valid_i && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end

    assign bus.stall_cnt_o = stall_cnt_reg;
`endif

    assign bus.lane_o      = lane_bus;
    assign bus.vec_ready_o = (state_reg == FD_FEED);
    assign bus.busy_o      = (state_reg != FD_IDLE);
    assign bus.advance_o   = advance_reg;
    assign bus.done_o      = done_reg;
endmodule
